// File: rtl/wb_uart_echo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_echo_pkg
// Purpose  : Shared types and constants for the UART echo bus master:
//            FSM state encoding, mode codes, payload width and the
//            byte transform applied on the receive path.
// Revision : 1.0 - initial release
// ============================================================================
package wb_uart_echo_pkg;

  // Payload carried per bus transaction (dat[7:0]).
  localparam int PAYLOAD_W = 8;

  // Consecutive reads (with data queued) allowed before a write is forced.
  localparam int STARVE_LIMIT = 4;

  // Operating modes selected by mode_i.
  localparam logic [1:0] MODE_ECHO = 2'd0;
  localparam logic [1:0] MODE_XOR  = 2'd1;
  localparam logic [1:0] MODE_SINK = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // Bus master FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } state_t;

  // Byte transform applied at read ack. Reserved mode behaves as echo;
  // sink mode is handled by suppressing the push, not here.
  function automatic logic [PAYLOAD_W-1:0] transform_byte(
    input logic [1:0]           mode,
    input logic [PAYLOAD_W-1:0] data,
    input logic [PAYLOAD_W-1:0] mask
  );
    return (mode == MODE_XOR) ? (data ^ mask) : data;
  endfunction

endpackage : wb_uart_echo_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with combinational head output, full/empty
//            flags and an occupancy count that reaches DEPTH when full.
//            Simultaneous push and pop are supported.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
  import wb_uart_echo_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted only when accompanied by a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign head  = mem[rd_ptr];

  // Storage array; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/wb_uart_echo_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_echo_master
// Purpose  : Wishbone B4 pipelined master that drains RX bytes from a UART
//            slave into a local FIFO, optionally transforms them, and writes
//            them back to the slave for transmission. Provides read/write
//            arbitration with anti-starvation, a bus timeout and status.
// Revision : 1.0 - initial release
// ============================================================================
module wb_uart_echo_master
  import wb_uart_echo_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 4,
  parameter int         RX_ADDR        = 0,
  parameter int         TX_ADDR        = 0,
  parameter int         FIFO_DEPTH     = 16,
  parameter logic [7:0] XOR_MASK       = 8'h20,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  output logic                          wb_we_o,
  output logic [ADDR_WIDTH-1:0]         wb_adr_o,
  output logic [DATA_WIDTH-1:0]         wb_dat_o,
  input  logic [DATA_WIDTH-1:0]         wb_dat_i,
  input  logic                          wb_ack_i,
  input  logic                          wb_stall_i,
  input  logic                          int_rx_i,
  input  logic [1:0]                    mode_i,
  input  logic                          err_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [15:0]                   rx_count_o,
  output logic                          err_o
);

  localparam int                    LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int                    TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit                    TMO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0]      TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]            STREAK_MAX = 3'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] RX_A       = ADDR_WIDTH'(RX_ADDR);
  localparam logic [ADDR_WIDTH-1:0] TX_A       = ADDR_WIDTH'(TX_ADDR);

  state_t                 state;
  state_t                 state_nxt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   tmo_hit;
  logic                   timeout;
  logic [2:0]             rd_streak;
  logic                   streak_hit;
  logic                   rd_grant;
  logic                   wr_grant;
  logic                   rd_ack;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PAYLOAD_W-1:0]   fifo_head;
  logic [PAYLOAD_W-1:0]   push_byte;
  logic [LVL_W-1:0]       fifo_level;
  logic [15:0]            rx_count;
  logic                   err;
  logic                   unused_dat_hi;

  // Only the low byte of read data carries payload.
  assign unused_dat_hi = ^wb_dat_i[DATA_WIDTH-1:PAYLOAD_W];

  // Mode is sampled at the read ack, so queued bytes keep the transform
  // that was active when they arrived.
  assign push_byte  = transform_byte(mode_i, wb_dat_i[PAYLOAD_W-1:0], XOR_MASK);
  assign tmo_hit    = TMO_EN && (tmo_cnt == TMO_LAST);
  assign streak_hit = (rd_streak == STREAK_MAX);

  sync_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .push      (fifo_push),
    .push_data (push_byte),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Next-state, arbitration and bus outputs. Bus progress (stall release or
  // ack) takes precedence over a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    rd_grant  = 1'b0;
    wr_grant  = 1'b0;
    rd_ack    = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    timeout   = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_adr_o  = '0;
    wb_dat_o  = '0;
    case (state)
      ST_IDLE: begin
        if (streak_hit && !fifo_empty) begin
          state_nxt = ST_WR_REQ;
          wr_grant  = 1'b1;
        end else if (int_rx_i && !fifo_full) begin
          state_nxt = ST_RD_REQ;
          rd_grant  = 1'b1;
        end else if (!fifo_empty) begin
          state_nxt = ST_WR_REQ;
          wr_grant  = 1'b1;
        end
      end
      ST_RD_REQ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_adr_o = RX_A;
        if (!wb_stall_i) begin
          state_nxt = ST_RD_WAIT;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        wb_cyc_o = 1'b1;
        wb_adr_o = RX_A;
        if (wb_ack_i) begin
          state_nxt = ST_IDLE;
          rd_ack    = 1'b1;
          fifo_push = (mode_i != MODE_SINK);
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      ST_WR_REQ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = TX_A;
        wb_dat_o = {{(DATA_WIDTH-PAYLOAD_W){1'b0}}, fifo_head};
        if (!wb_stall_i) begin
          state_nxt = ST_WR_WAIT;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = TX_A;
        wb_dat_o = {{(DATA_WIDTH-PAYLOAD_W){1'b0}}, fifo_head};
        if (wb_ack_i) begin
          state_nxt = ST_IDLE;
          fifo_pop  = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timeout counter: restarts on every state change, counts while on the bus.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_cnt <= '0;
    end else if (state_nxt != state) begin
      tmo_cnt <= '0;
    end else if (TMO_EN && wb_cyc_o) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Anti-starvation: count reads granted while data is already queued.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rd_streak <= '0;
    end else if (wr_grant) begin
      rd_streak <= '0;
    end else if (rd_grant) begin
      if (fifo_empty) begin
        rd_streak <= '0;
      end else if (!streak_hit) begin
        rd_streak <= rd_streak + 3'd1;
      end
    end
  end

  // Received-byte counter, including bytes discarded in sink mode.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rx_count <= '0;
    end else if (rd_ack) begin
      rx_count <= rx_count + 16'd1;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else if (err_clr_i) begin
      err <= 1'b0;
    end
  end

  assign level_o    = fifo_level;
  assign rx_count_o = rx_count;
  assign err_o      = err;

endmodule : wb_uart_echo_master
`default_nettype wire
